// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller.
// Enabling macro MC_CTRL_HS_JAL_JR_EN adds the JAL and JR states.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEXE  = 4'd6,
        RTWB   = 4'd7,
        IEXE   = 4'd8,
        IWB    = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
`ifdef MC_CTRL_HS_JAL_JR_EN
        JAL    = 4'd12,
        JR     = 4'd13,
`endif
        TRAP   = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_NONE  = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;
    localparam logic [2:0] ALU_PASSA = 3'd6;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] GPR_RD = 2'b00;
    localparam logic [1:0] GPR_RT = 2'b01;
    localparam logic [1:0] GPR_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    function automatic logic is_req_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags the cycle
// in which the count would reach TO_CYCLES.
module mc_wait_timer #(
    parameter int unsigned TO_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic req_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam logic [7:0] TO_MAX  = 8'(TO_CYCLES);
    localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i || ready_i) begin
            count_d = '0;
        end else if (req_i && (count_q != TO_MAX)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flag one cycle early so the FSM moves to TRAP as the count hits the limit.
    assign timeout_o = req_i && !ready_i && (count_q >= TO_LAST);

endmodule

// File: rtl/mc_ctrl_hs.sv
// Multicycle datapath controller with memory handshake and timeout trap.
// Macro MC_CTRL_HS_JAL_JR_EN enables the jal and jr instructions.
module mc_ctrl_hs
    import mc_pkg::*;
#(
    parameter int unsigned TO_CYCLES = 15,
    parameter int unsigned ALUOP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               EXTOp,
    output logic               IorD,
    output logic               ALUSrcA,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               trap,
    output logic [3:0]         state_o
);

    state_t     state_q, state_d;
    logic [2:0] alu_sel;
    logic       timeout;
    logic       req_state;
    logic       enter_req;

    assign req_state = is_req_state(state_q);
    assign enter_req = is_req_state(state_d) && (state_d != state_q);

    mc_wait_timer #(.TO_CYCLES(TO_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (enter_req),
        .req_i    (req_state),
        .ready_i  (mem_ready),
        .timeout_o(timeout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        EXTOp    = 1'b0;
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        alu_sel  = ALU_NONE;
        PCSource = PC_ALU;
        ALUSrcB  = SRCB_REG;
        GPRSel   = GPR_RD;
        WDSel    = WD_ALU;
        trap     = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    PCWrite = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    alu_sel = ALU_ADD;
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end
            DECODE: begin
                ALUSrcB = SRCB_BRANCH;
                alu_sel = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW:    state_d = MEMADR;
`ifdef MC_CTRL_HS_JAL_JR_EN
                    OP_RTYPE:        state_d = (Funct == FN_JR) ? JR : RTEXE;
                    OP_JAL:          state_d = JAL;
`else
                    OP_RTYPE:        state_d = (Funct == FN_JR) ? TRAP : RTEXE;
`endif
                    OP_ADDI, OP_ORI: state_d = IEXE;
                    OP_BEQ, OP_BNE:  state_d = BRANCH;
                    OP_J:            state_d = JUMP;
                    default:         state_d = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                EXTOp   = 1'b1;
                alu_sel = ALU_ADD;
                state_d = (Op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                if (mem_ready)    state_d = MEMWB;
                else if (timeout) state_d = TRAP;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                GPRSel   = GPR_RT;
                WDSel    = WD_MEM;
                state_d  = FETCH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = mem_ready;
                if (mem_ready)    state_d = FETCH;
                else if (timeout) state_d = TRAP;
            end
            RTEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_REG;
                state_d = RTWB;
                case (Funct)
                    FN_ADD:  alu_sel = ALU_ADD;
                    FN_SUB:  alu_sel = ALU_SUB;
                    FN_AND:  alu_sel = ALU_AND;
                    FN_OR:   alu_sel = ALU_OR;
                    FN_SLT:  alu_sel = ALU_SLT;
                    default: state_d = TRAP;
                endcase
            end
            RTWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            IEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                EXTOp   = (Op == OP_ADDI);
                alu_sel = (Op == OP_ADDI) ? ALU_ADD : ALU_OR;
                state_d = IWB;
            end
            IWB: begin
                RegWrite = 1'b1;
                GPRSel   = GPR_RT;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                alu_sel  = ALU_SUB;
                PCSource = PC_ALUOUT;
                PCWrite  = (Op == OP_BEQ) ? Zero : ~Zero;
                state_d  = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PC_JUMP;
                state_d  = FETCH;
            end
`ifdef MC_CTRL_HS_JAL_JR_EN
            JAL: begin
                PCWrite  = 1'b1;
                PCSource = PC_JUMP;
                RegWrite = 1'b1;
                GPRSel   = GPR_RA;
                WDSel    = WD_PC;
                state_d  = FETCH;
            end
            JR: begin
                ALUSrcA  = 1'b1;
                alu_sel  = ALU_PASSA;
                PCWrite  = 1'b1;
                state_d  = FETCH;
            end
`endif
            TRAP: trap = 1'b1;
            default: state_d = TRAP;
        endcase
        // Outputs are forced low while reset is held; next state is left ungated.
        if (!rst) begin
            mem_req  = 1'b0;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            EXTOp    = 1'b0;
            IorD     = 1'b0;
            ALUSrcA  = 1'b0;
            alu_sel  = ALU_NONE;
            PCSource = '0;
            ALUSrcB  = '0;
            GPRSel   = '0;
            WDSel    = '0;
            trap     = 1'b0;
        end
    end

    assign ALUOp   = ALUOP_W'(alu_sel);
    assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Directed self-checking bench for mc_ctrl_hs (default TO_CYCLES=15).
module tb_mc_ctrl_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero, mem_ready;
    logic       mem_req, PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, IorD, ALUSrcA;
    logic [3:0] ALUOp;
    logic [1:0] PCSource, ALUSrcB, GPRSel, WDSel;
    logic       trap;
    logic [3:0] state_o;

    int unsigned errors = 0;
    int unsigned checks = 0;

    mc_ctrl_hs #(.TO_CYCLES(15), .ALUOP_W(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .EXTOp(EXTOp), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUOp(ALUOp),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .GPRSel(GPRSel),
        .WDSel(WDSel), .trap(trap), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b0; Op = 6'h23; Funct = 6'h00; Zero = 1'b0; mem_ready = 1'b1;
        #3;
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_req", 32'(mem_req), 32'd0);
        chk("reset_pcwrite", 32'(PCWrite), 32'd0);
        chk("reset_trap", 32'(trap), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;

        // lw, no waits
        chk("lw_fetch_state", 32'(state_o), 32'd0);
        chk("lw_fetch_req", 32'(mem_req), 32'd1);
        chk("lw_fetch_pcw", 32'(PCWrite), 32'd1);
        chk("lw_fetch_irw", 32'(IRWrite), 32'd1);
        chk("lw_fetch_srcb", 32'(ALUSrcB), 32'd1);
        chk("lw_fetch_alu", 32'(ALUOp), 32'd1);
        tick();
        chk("lw_dec_state", 32'(state_o), 32'd1);
        chk("lw_dec_srcb", 32'(ALUSrcB), 32'd3);
        tick();
        chk("lw_adr_state", 32'(state_o), 32'd2);
        chk("lw_adr_ext", 32'(EXTOp), 32'd1);
        chk("lw_adr_srcb", 32'(ALUSrcB), 32'd2);
        tick();
        chk("lw_rd_state", 32'(state_o), 32'd3);
        chk("lw_rd_iord", 32'(IorD), 32'd1);
        tick();
        chk("lw_wb_state", 32'(state_o), 32'd4);
        chk("lw_wb_regw", 32'(RegWrite), 32'd1);
        chk("lw_wb_wdsel", 32'(WDSel), 32'd1);
        chk("lw_wb_gpr", 32'(GPRSel), 32'd1);
        tick();
        chk("lw_done", 32'(state_o), 32'd0);

        // sw with three wait cycles in MEMWR
        Op = 6'h2B;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        chk("sw_wr_state", 32'(state_o), 32'd5);
        for (int i = 0; i < 3; i++) begin
            chk("sw_wait_memw", 32'(MemWrite), 32'd0);
            chk("sw_wait_state", 32'(state_o), 32'd5);
            if (i < 2) tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("sw_ready_memw", 32'(MemWrite), 32'd1);
        tick();
        chk("sw_done_state", 32'(state_o), 32'd0);
        chk("sw_done_memw", 32'(MemWrite), 32'd0);

        // beq taken, bne with Zero=1 not taken
        Op = 6'h04; Zero = 1'b1;
        tick(); tick();
        #1;
        chk("beq_state", 32'(state_o), 32'd10);
        chk("beq_pcw", 32'(PCWrite), 32'd1);
        chk("beq_pcsrc", 32'(PCSource), 32'd1);
        chk("beq_alu", 32'(ALUOp), 32'd2);
        tick();
        Op = 6'h05;
        tick(); tick();
        #1;
        chk("bne_pcw", 32'(PCWrite), 32'd0);
        Zero = 1'b0;
        #1;
        chk("bne_nz_pcw", 32'(PCWrite), 32'd1);
        tick();

        // R-type sub
        Op = 6'h00; Funct = 6'h22;
        tick(); tick();
        chk("sub_state", 32'(state_o), 32'd6);
        chk("sub_alu", 32'(ALUOp), 32'd2);
        tick();
        chk("sub_wb_regw", 32'(RegWrite), 32'd1);
        chk("sub_wb_gpr", 32'(GPRSel), 32'd0);
        tick();

        // ori
        Op = 6'h0D;
        tick(); tick();
        chk("ori_state", 32'(state_o), 32'd8);
        chk("ori_alu", 32'(ALUOp), 32'd4);
        chk("ori_ext", 32'(EXTOp), 32'd0);
        tick();
        chk("ori_wb_gpr", 32'(GPRSel), 32'd1);
        tick();

        // j
        Op = 6'h02;
        tick(); tick();
        chk("j_state", 32'(state_o), 32'd11);
        chk("j_pcsrc", 32'(PCSource), 32'd2);
        chk("j_pcw", 32'(PCWrite), 32'd1);
        tick();
        chk("j_done", 32'(state_o), 32'd0);

        // ready arriving with counter at TO_CYCLES-1 completes normally (jal)
        Op = 6'h03;
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("edge_state", 32'(state_o), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("edge_pcw", 32'(PCWrite), 32'd1);
        tick();
        chk("edge_decode", 32'(state_o), 32'd1);
        chk("edge_trap", 32'(trap), 32'd0);
        tick();
`ifdef MC_CTRL_HS_JAL_JR_EN
        chk("jal_state", 32'(state_o), 32'd12);
        chk("jal_regw", 32'(RegWrite), 32'd1);
        chk("jal_gpr", 32'(GPRSel), 32'd2);
        chk("jal_wd", 32'(WDSel), 32'd2);
`else
        chk("jal_trap_state", 32'(state_o), 32'd14);
        chk("jal_trap", 32'(trap), 32'd1);
`endif
        do_reset();

        // jr
        Op = 6'h00; Funct = 6'h08;
        tick(); tick();
`ifdef MC_CTRL_HS_JAL_JR_EN
        chk("jr_state", 32'(state_o), 32'd13);
        chk("jr_alu", 32'(ALUOp), 32'd6);
        chk("jr_pcw", 32'(PCWrite), 32'd1);
`else
        chk("jr_trap", 32'(trap), 32'd1);
`endif
        do_reset();

        // illegal opcode
        Op = 6'h3F;
        tick();
        chk("ill_decode", 32'(state_o), 32'd1);
        tick();
        chk("ill_state", 32'(state_o), 32'd14);
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_req", 32'(mem_req), 32'd0);
        tick(); tick();
        chk("ill_sticky", 32'(trap), 32'd1);
        do_reset();

        // fetch timeout after 15 stalled cycles
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("to_before", 32'(trap), 32'd0);
        tick();
        chk("to_trap", 32'(trap), 32'd1);
        chk("to_state", 32'(state_o), 32'd14);
        mem_ready = 1'b1;
        tick(); tick();
        chk("to_sticky", 32'(trap), 32'd1);
        do_reset();

        // reset in the middle of a store
        Op = 6'h2B;
        tick(); tick(); tick();
        chk("rsw_memw", 32'(MemWrite), 32'd1);
        rst = 1'b0;
        #1;
        chk("rsw_drop", 32'(MemWrite), 32'd0);
        chk("rsw_state", 32'(state_o), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rsw_fetch", 32'(state_o), 32'd0);
        chk("rsw_req", 32'(mem_req), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
